// File: rtl/m_demux_2_buf.sv
// Two-way demultiplexer with an independent DEPTH-entry FIFO per output channel.
// Optional per-channel output-transfer counters are enabled with `define M_DEMUX_2_BUF_CNT_EN.
module m_demux_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic             out0_full,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             out1_full
`ifdef M_DEMUX_2_BUF_CNT_EN
  ,
  output logic [15:0]      xfer_cnt0,
  output logic [15:0]      xfer_cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    wr_ptr_d [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [AW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    cnt_q    [2];
  logic [CW-1:0]    cnt_d    [2];

  logic [1:0] full;
  logic [1:0] nonempty;
  logic [1:0] out_ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic       sel_ch1;

  // An X or Z select falls through the if and steers to channel 0.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_ch1 = 1'b0;
    if (in_sel == 1'b1) sel_ch1 = 1'b1;
  end

  assign out_ready = {out1_ready, out0_ready};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]     = (cnt_q[c] == CW'(DEPTH));
      nonempty[c] = (cnt_q[c] != '0);
    end
  end

  // Ready looks only at the selected channel's occupancy, never at the consumer side.
  assign in_ready = sel_ch1 ? ~full[1] : ~full[0];
  assign push[0]  = in_valid & in_ready & ~sel_ch1;
  assign push[1]  = in_valid & in_ready &  sel_ch1;
  assign pop      = nonempty & out_ready;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
      if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
    end
  end

  // NOTE: storage is cleared on reset too, so the head word of an empty channel reads 0.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data;
      end
    end
  end

  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];
  assign out0_valid = nonempty[0];
  assign out1_valid = nonempty[1];
  assign out0_full  = full[0];
  assign out1_full  = full[1];

`ifdef M_DEMUX_2_BUF_CNT_EN
  logic [15:0] xfer_cnt_q [2];
  logic [15:0] xfer_cnt_d [2];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      xfer_cnt_d[c] = xfer_cnt_q[c];
      if (pop[c] && (xfer_cnt_q[c] != 16'hFFFF)) xfer_cnt_d[c] = xfer_cnt_q[c] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) xfer_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) xfer_cnt_q[c] <= xfer_cnt_d[c];
    end
  end

  assign xfer_cnt0 = xfer_cnt_q[0];
  assign xfer_cnt1 = xfer_cnt_q[1];
`endif

endmodule

// File: tb/tb_m_demux_2_buf.sv
// Self-checking bench for m_demux_2_buf: fixed vector table, corner-case sequences,
// and random traffic against a queue-based reference model.
module tb_m_demux_2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic             out0_full, out1_full;
`ifdef M_DEMUX_2_BUF_CNT_EN
  logic [15:0]      xfer_cnt0, xfer_cnt1;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_demux_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_full  (out0_full),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_full  (out1_full)
`ifdef M_DEMUX_2_BUF_CNT_EN
    ,
    .xfer_cnt0  (xfer_cnt0),
    .xfer_cnt1  (xfer_cnt1)
`endif
  );

  typedef struct {
    logic             iv;
    logic             sel;
    logic [WIDTH-1:0] d;
    logic             r0;
    logic             r1;
    logic             e_rdy;
    logic             e_v0;
    logic [WIDTH-1:0] e_d0;
    logic             e_v1;
    logic [WIDTH-1:0] e_d1;
    logic             e_f0;
    logic             e_f1;
  } vec_t;

  vec_t tbl [15];

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = iv;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: drive at the falling edge, let the rising edge happen, settle 1 time unit.
  task automatic cycle(input logic iv, input logic sel, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    @(negedge clk);
    drive(iv, sel, d, r0, r1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

    //             iv sel data         r0 r1  rdy v0 d0           v1 d1     f0 f1
    tbl[0]  = '{1, 0, 32'hA5A5A5A5, 0, 0,  1,  1, 32'hA5A5A5A5, 0, 32'h0,  0, 0};
    tbl[1]  = '{1, 1, 32'h1,        0, 0,  1,  1, 32'hA5A5A5A5, 1, 32'h1,  0, 0};
    tbl[2]  = '{1, 1, 32'h2,        0, 0,  1,  1, 32'hA5A5A5A5, 1, 32'h1,  0, 1};
    tbl[3]  = '{1, 1, 32'h3,        0, 1,  0,  1, 32'hA5A5A5A5, 1, 32'h2,  0, 0};
    tbl[4]  = '{1, 0, 32'h3,        1, 0,  1,  1, 32'h3,        1, 32'h2,  0, 0};
    tbl[5]  = '{0, 0, 32'h0,        1, 1,  1,  0, 32'hA5A5A5A5, 0, 32'h1,  0, 0};
    tbl[6]  = '{1, 1, 32'h77,       0, 1,  1,  0, 32'hA5A5A5A5, 1, 32'h77, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        1, 0,  1,  0, 32'hA5A5A5A5, 1, 32'h77, 0, 0};
    tbl[8]  = '{1, 0, 32'h10,       0, 1,  1,  1, 32'h10,       0, 32'h2,  0, 0};
    tbl[9]  = '{1, 1, 32'h21,       0, 0,  1,  1, 32'h10,       1, 32'h21, 0, 0};
    tbl[10] = '{1, 1, 32'h22,       0, 0,  1,  1, 32'h10,       1, 32'h21, 0, 1};
    tbl[11] = '{1, 0, 32'h11,       0, 0,  1,  1, 32'h10,       1, 32'h21, 1, 1};
    tbl[12] = '{1, 1, 32'h99,       0, 0,  0,  1, 32'h10,       1, 32'h21, 1, 1};
    tbl[13] = '{1, 0, 32'h99,       0, 0,  0,  1, 32'h10,       1, 32'h21, 1, 1};
    tbl[14] = '{0, 0, 32'h0,        1, 1,  0,  1, 32'h11,       1, 32'h22, 0, 0};

    // Reset state
    do_reset();
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(1'b1));
    check("reset_outputs",
          128'({out0_valid, out0_data, out1_valid, out1_data, out0_full, out1_full}), 128'(0));

    // Vector table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      check($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_outputs", i),
            128'({out0_valid, out0_data, out1_valid, out1_data, out0_full, out1_full}),
            128'({tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_v1, tbl[i].e_d1, tbl[i].e_f0, tbl[i].e_f1}));
    end

    // Unknown select goes to channel 0; no combinational pass-through before the edge
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'bx, 32'h11, 1'b0, 1'b0);
    #1;
    check("xsel_no_comb_valid", 128'({out0_valid, out1_valid}), 128'(2'b00));
    @(posedge clk);
    #1;
    check("xsel_ch0", 128'({out0_valid, out0_data, out1_valid}), 128'({1'b1, 32'h11, 1'b0}));

    // Asynchronous reset with both channels full, then first edge after release accepts
    do_reset();
    cycle(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
    check("both_full", 128'({out0_full, out1_full}), 128'(2'b11));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_reset_clears",
          128'({in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_full, out1_full}),
          128'({1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}));
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first_after_reset",
          128'({out1_valid, out1_data, out0_valid}), 128'({1'b1, 32'h5A, 1'b0}));

    // Random traffic against a queue model
    do_reset();
    q0.delete();
    q1.delete();
    for (int n = 0; n < 3000; n++) begin
      logic iv, sel, r0, r1, e_rdy, p0, p1;
      logic [WIDTH-1:0] d;
      iv  = 1'($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      r0  = 1'($urandom_range(0, 2) == 0);
      r1  = 1'($urandom_range(0, 1));
      d   = $urandom;
      @(negedge clk);
      drive(iv, sel, d, r0, r1);
      #1;
      e_rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      check("rnd_in_ready", 128'(in_ready), 128'(e_rdy));
      p0 = r0 && (q0.size() > 0);
      p1 = r1 && (q1.size() > 0);
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (iv && e_rdy) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
      #1;
      check("rnd_status", 128'({out0_valid, out0_full, out1_valid, out1_full}),
            128'({q0.size() > 0, q0.size() == DEPTH, q1.size() > 0, q1.size() == DEPTH}));
      if (q0.size() > 0) check("rnd_out0_data", 128'(out0_data), 128'(q0[0]));
      if (q1.size() > 0) check("rnd_out1_data", 128'(out1_data), 128'(q1[0]));
    end

`ifdef M_DEMUX_2_BUF_CNT_EN
    // Saturating transfer counter: first edge fills channel 0, the next 70000 each pop once
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hC0FFEE, 1'b1, 1'b0);
    repeat (70001) @(posedge clk);
    #1;
    check("xfer_cnt0_sat", 128'(xfer_cnt0), 128'(16'hFFFF));
    check("xfer_cnt1_zero", 128'(xfer_cnt1), 128'(16'h0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/m_demux_2_buf.md
M_DEMUX_2_BUF -- requirements
Module: M_DEMUX_2_BUF

Interface
REQ-001 Parameter: WIDTH, default 32, data width of input and both output channels.
REQ-002 Parameter: DEPTH, default 2, entries per channel FIFO; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word to be steered.
REQ-006 in_sel  input  1  destination select; 1 -> channel 1, any other value (0, X, Z) -> channel 0.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  selected channel can accept this cycle.
REQ-009 out0_data, out1_data  output  WIDTH  head entry of channel 0 / 1.
REQ-010 out0_valid, out1_valid  output  1  channel FIFO non-empty.
REQ-011 out0_ready, out1_ready  input  1  consumer takes head entry this cycle.
REQ-012 out0_full, out1_full  output  1  channel FIFO holds DEPTH entries.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready at a clk edge; word written to tail of the selected channel.
REQ-014 in_ready SHALL be combinational: !out1_full when in_sel==1, else !out0_full; no dependence on outN_ready.
REQ-015 Output transfer on channel N SHALL occur when outN_valid && outN_ready; head entry removed at that edge.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge k is visible on outN_data/outN_valid after edge k, never combinationally.
REQ-017 Each channel SHALL preserve FIFO order; no ordering is guaranteed between channels.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-019 Simultaneous push and pop on same non-empty, non-full channel SHALL leave occupancy unchanged.
REQ-020 Push into an empty channel with outN_ready=1 in the same cycle SHALL NOT pop (valid is still 0); word appears next cycle.
REQ-021 Full channel SHALL deassert in_ready for its select even if outN_ready=1 that cycle (no pass-through on full).
REQ-022 outN_ready while outN_valid=0 SHALL have no effect; pops from empty channel SHALL NOT underflow pointers.
REQ-023 Activity on one channel SHALL NOT stall the other: a full channel 1 never blocks in_sel=0 transfers.
REQ-024 outN_data when outN_valid=0 SHALL be the last stored value at the read pointer (0 after reset).

Reset
REQ-025 reset=1 SHALL asynchronously clear pointers, occupancy, and storage to 0: out0/1_valid=0, out0/1_full=0, out0/1_data=0, in_ready=1.
REQ-026 Reset mid-operation SHALL discard all buffered words; no transfer is reported at the edge reset is sampled.
REQ-027 First transfer SHALL be accepted on the first clk edge after reset deasserts.

Configuration
REQ-028 Macro M_DEMUX_2_BUF_CNT_EN defined: add outputs xfer_cnt0, xfer_cnt1 (16 bits each), counting output transfers per channel, saturating at 16'hFFFF, cleared by reset.
REQ-029 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, then push 0xA5A5A5A5 sel=0, out0_ready=0 -> out0_valid=1, out0_data=0xA5A5A5A5 next cycle; out1_valid stays 0.
REQ-031 in_sel=X with in_valid=1, data 0x11 -> word appears on channel 0 only.
REQ-032 DEPTH=2, out1_ready=0, push 0x1,0x2 sel=1 -> out1_full=1, in_ready=0 for sel=1, in_ready=1 for sel=0; then out1_ready=1 -> pops 0x1 then 0x2 in order.
REQ-033 Channel 0 at occupancy 1, simultaneous push 0x3 and pop -> occupancy stays 1, next out0_data=0x3.
REQ-034 Assert reset with 2 words in each channel -> all valid/full drop immediately, out data=0, in_ready=1.
REQ-035 With M_DEMUX_2_BUF_CNT_EN, 70000 pops on channel 0 -> xfer_cnt0=0xFFFF, xfer_cnt1=0.
